// File: rtl/lfsr_keystream_ctrl.sv
// LFSR keystream sequencer: loads seed/taps, discards a warm-up run, then packs
// feedback bits MSB-first into words delivered on a valid/ready stream.
module lfsr_keystream_ctrl #(
    parameter int LFSR_WIDTH = 6,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic [LFSR_WIDTH:0]   coeff,
    input  logic [CNT_WIDTH-1:0]  warmup_cycles,
    output logic [OUT_WIDTH-1:0]  out_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  seed_err,
    output logic [LFSR_WIDTH-1:0] lfsr_state
);

    localparam int BIT_CW = $clog2(OUT_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Tap bit 0 lines up with a constant zero, so it never influences feedback.
    function automatic logic fb_parity(input logic [LFSR_WIDTH-1:0] st,
                                       input logic [LFSR_WIDTH:0]   taps);
        return ^({st, 1'b0} & taps);
    endfunction

    state_t                fsm_r;
    state_t                fsm_nxt_s;
    logic [LFSR_WIDTH-1:0] state_r;
    logic [LFSR_WIDTH:0]   coeff_r;
    logic [CNT_WIDTH-1:0]  warm_cnt_r;
    logic [BIT_CW-1:0]     bit_cnt_r;
    logic [OUT_WIDTH-1:0]  shreg_r;
    logic [OUT_WIDTH-1:0]  out_word_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic                  seed_err_r;
    logic                  stop_pending_r;

    logic                  fb_s;
    logic [OUT_WIDTH:0]    shreg_ext_s;
    logic [OUT_WIDTH-1:0]  shreg_nxt_s;
    logic                  load_s;
    logic                  shift_s;
    logic                  seed_err_s;
    logic                  word_done_s;
    logic                  take_s;
    logic                  pend_set_s;

    assign fb_s        = fb_parity(state_r, coeff_r);
    assign shreg_ext_s = {shreg_r, fb_s};
    assign shreg_nxt_s = shreg_ext_s[OUT_WIDTH-1:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r <= ST_IDLE;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // Next-state decode and datapath strobes; stop wins over shifting.
    always_comb begin
        fsm_nxt_s   = fsm_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        seed_err_s  = 1'b0;
        word_done_s = 1'b0;
        take_s      = 1'b0;
        pend_set_s  = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                if (start) begin
                    if (seed != {LFSR_WIDTH{1'b0}}) begin
                        load_s = 1'b1;
                        if (warmup_cycles != {CNT_WIDTH{1'b0}}) begin
                            fsm_nxt_s = ST_WARMUP;
                        end else begin
                            fsm_nxt_s = ST_FILL;
                        end
                    end else begin
                        seed_err_s = 1'b1;
                    end
                end else begin
                    fsm_nxt_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    fsm_nxt_s = ST_IDLE;
                end else begin
                    shift_s = 1'b1;
                    if (warm_cnt_r == CNT_WIDTH'(1)) begin
                        fsm_nxt_s = ST_FILL;
                    end else begin
                        fsm_nxt_s = ST_WARMUP;
                    end
                end
            end
            ST_FILL: begin
                if (stop) begin
                    fsm_nxt_s = ST_IDLE;
                end else begin
                    shift_s = 1'b1;
                    if (bit_cnt_r == BIT_CW'(OUT_WIDTH - 1)) begin
                        word_done_s = 1'b1;
                        fsm_nxt_s   = ST_HOLD;
                    end else begin
                        fsm_nxt_s = ST_FILL;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    take_s = 1'b1;
                    if (stop_pending_r || stop) begin
                        fsm_nxt_s = ST_IDLE;
                    end else begin
                        fsm_nxt_s = ST_FILL;
                    end
                end else if (stop) begin
                    pend_set_s = 1'b1;
                end else begin
                    fsm_nxt_s = ST_HOLD;
                end
            end
            default: begin
                fsm_nxt_s = ST_IDLE;
            end
        endcase
    end

    // LFSR, counters, packing register and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= {LFSR_WIDTH{1'b0}};
            coeff_r        <= {(LFSR_WIDTH + 1){1'b0}};
            warm_cnt_r     <= {CNT_WIDTH{1'b0}};
            bit_cnt_r      <= {BIT_CW{1'b0}};
            shreg_r        <= {OUT_WIDTH{1'b0}};
            out_word_r     <= {OUT_WIDTH{1'b0}};
            out_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
            seed_err_r     <= 1'b0;
            stop_pending_r <= 1'b0;
        end else begin
            if (load_s) begin
                state_r    <= seed;
                coeff_r    <= coeff;
                warm_cnt_r <= warmup_cycles;
                bit_cnt_r  <= {BIT_CW{1'b0}};
                shreg_r    <= {OUT_WIDTH{1'b0}};
            end else if (shift_s) begin
                state_r <= {state_r[LFSR_WIDTH-2:0], fb_s};
                if (fsm_r == ST_WARMUP) begin
                    warm_cnt_r <= warm_cnt_r - CNT_WIDTH'(1);
                end else begin
                    shreg_r   <= shreg_nxt_s;
                    bit_cnt_r <= word_done_s ? {BIT_CW{1'b0}} : bit_cnt_r + BIT_CW'(1);
                end
            end else if (fsm_r == ST_FILL) begin
                // Aborted fill: drop the partial word so a restart packs cleanly.
                bit_cnt_r <= {BIT_CW{1'b0}};
            end

            if (word_done_s) begin
                out_word_r  <= shreg_nxt_s;
                out_valid_r <= 1'b1;
            end else if (take_s) begin
                out_valid_r <= 1'b0;
            end

            if (fsm_nxt_s == ST_IDLE) begin
                stop_pending_r <= 1'b0;
            end else if (pend_set_s) begin
                stop_pending_r <= 1'b1;
            end

            busy_r     <= (fsm_nxt_s != ST_IDLE);
            seed_err_r <= seed_err_s;
        end
    end

    assign out_word   = out_word_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign seed_err   = seed_err_r;
    assign lfsr_state = state_r;

endmodule

// File: tb/tb_lfsr_keystream_ctrl.sv
// Scoreboard bench for lfsr_keystream_ctrl: a bit-level reference model queues
// expected words per session; a negedge monitor pops them on each handshake.
module tb_lfsr_keystream_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, out_ready;
    logic [3:0] seed;
    logic [4:0] coeff;
    logic [7:0] warmup_cycles;
    logic [7:0] out_word;
    logic       out_valid, busy, seed_err;
    logic [3:0] lfsr_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] word;
        logic [3:0] st;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [3:0] model_last_st = 4'd0;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_word = 8'd0;
    logic [3:0] prev_st = 4'd0;

    localparam logic [4:0] BASE_C = 5'b10010;

    always #5 clk = ~clk;

    lfsr_keystream_ctrl #(.LFSR_WIDTH(4), .OUT_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed),
        .coeff(coeff), .warmup_cycles(warmup_cycles), .out_word(out_word),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .seed_err(seed_err), .lfsr_state(lfsr_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One shift: feedback is the parity of the tapped bits, appended at the bottom.
    function automatic logic [3:0] ref_step(input logic [3:0] s, input logic [4:0] c, output logic b);
        b = (($countones(s & c[4:1]) % 2) == 1);
        return 4'((int'(s) * 2 + int'(b)) % 16);
    endfunction

    task automatic model_session(input logic [3:0] sd, input logic [4:0] c,
                                 input int n, input int nwords);
        logic [3:0] s;
        logic       b;
        int         w;
        s = sd;
        for (int i = 0; i < n; i++) s = ref_step(s, c, b);
        for (int k = 0; k < nwords; k++) begin
            w = 0;
            for (int j = 0; j < 8; j++) begin
                s = ref_step(s, c, b);
                w = w * 2 + int'(b);
            end
            q.push_back('{word: 8'(w), st: s});
        end
        model_last_st = s;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [3:0] sd, input logic [4:0] c, input int n);
        seed = sd;
        coeff = c;
        warmup_cycles = 8'(n);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat, input string name);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 300) begin
            tick(1);
            cnt++;
        end
        check(name, cnt, exp_lat);
    endtask

    task automatic finish_word(input bit last);
        out_ready = 1'b1;
        stop = last;
        tick(1);
        out_ready = 1'b0;
        stop = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, out_word, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_seed_err"}, seed_err, 0);
        check({tag, "_state"}, lfsr_state, 0);
    endtask

    // Monitor: hold stability while stalled, scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_word", out_word, prev_word);
            check("hold_state", lfsr_state, prev_st);
        end
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", (q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                check("sb_word", out_word, mon_e.word);
                check("sb_state", lfsr_state, mon_e.st);
            end
        end
        prev_hold = !rst && out_valid && !out_ready;
        prev_word = out_word;
        prev_st = lfsr_state;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int n, nw;
        logic [3:0] sd;
        logic [4:0] c;

        rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        seed = 4'd0; coeff = 5'd0; warmup_cycles = 8'd0;
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // No warm-up, consumer always ready.
        model_session(4'b0001, BASE_C, 0, 1);
        out_ready = 1'b1;
        do_start(4'b0001, BASE_C, 0);
        check("w0_busy_start", busy, 1);
        wait_valid(8, "w0_latency");
        check("w0_word", out_word, 8'hEB);
        check("w0_state", lfsr_state, 4'b1011);
        check("w0_busy", busy, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        out_ready = 1'b0;
        check("w0_idle_busy", busy, 0);
        check("w0_idle_state_kept", lfsr_state, model_last_st);

        // Four discarded shifts.
        model_session(4'b0001, BASE_C, 4, 1);
        do_start(4'b0001, BASE_C, 4);
        wait_valid(12, "w4_latency");
        check("w4_word", out_word, 8'hB2);
        check("w4_state", lfsr_state, 4'b0010);
        finish_word(1'b1);
        check("w4_idle_busy", busy, 0);

        // Back-pressure for 5 cycles, then a second word.
        model_session(4'b0001, BASE_C, 0, 2);
        do_start(4'b0001, BASE_C, 0);
        wait_valid(8, "bp_latency");
        tick(5);
        check("bp_valid_held", out_valid, 1);
        check("bp_state_frozen", lfsr_state, 4'b1011);
        finish_word(1'b0);
        check("bp_valid_drop", out_valid, 0);
        check("bp_busy", busy, 1);
        wait_valid(8, "bp_next_latency");
        finish_word(1'b1);
        check("bp_idle_busy", busy, 0);

        // Zero seed is rejected with a one-cycle pulse.
        seed = 4'd0; coeff = BASE_C; warmup_cycles = 8'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("seed_err_pulse", seed_err, 1);
        check("seed_err_busy", busy, 0);
        check("seed_err_state", lfsr_state, model_last_st);
        tick(1);
        check("seed_err_clear", seed_err, 0);

        // Stop on fill bit 3: no word ever appears.
        out_ready = 1'b1;
        do_start(4'b0001, BASE_C, 0);
        tick(2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_fill_busy", busy, 0);
        vcnt = 0;
        repeat (12) begin
            vcnt += int'(out_valid);
            tick(1);
        end
        check("stop_fill_novalid", vcnt, 0);
        out_ready = 1'b0;

        // Stop while holding: word is still delivered, then idle.
        model_session(4'b0001, BASE_C, 0, 1);
        do_start(4'b0001, BASE_C, 0);
        wait_valid(8, "stop_hold_latency");
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_hold_valid", out_valid, 1);
        check("stop_hold_busy", busy, 1);
        tick(2);
        check("stop_hold_valid_later", out_valid, 1);
        finish_word(1'b0);
        check("stop_hold_idle_busy", busy, 0);
        check("stop_hold_idle_valid", out_valid, 0);

        // Reset in warm-up and in hold, then a clean restart.
        do_start(4'b0001, BASE_C, 10);
        tick(3);
        rst = 1'b1;
        tick(1);
        check_all_zero("rst_warm");
        rst = 1'b0;
        model_session(4'b0001, BASE_C, 0, 1);
        do_start(4'b0001, BASE_C, 0);
        wait_valid(8, "rst_hold_latency");
        rst = 1'b1;
        tick(1);
        check_all_zero("rst_hold");
        q.delete();
        rst = 1'b0;
        tick(1);
        model_session(4'b0001, BASE_C, 4, 1);
        do_start(4'b0001, BASE_C, 4);
        wait_valid(12, "post_rst_latency");
        check("post_rst_word", out_word, 8'hB2);
        finish_word(1'b1);

        // Randomized sessions with random stalls.
        for (int s = 0; s < 30; s++) begin
            sd = 4'($urandom_range(1, 15));
            c = 5'($urandom);
            n = int'($urandom_range(0, 12));
            nw = int'($urandom_range(1, 3));
            model_session(sd, c, n, nw);
            do_start(sd, c, n);
            for (int w = 0; w < nw; w++) begin
                wait_valid((w == 0) ? n + 8 : 8, "rand_latency");
                tick(int'($urandom_range(0, 3)));
                finish_word(w == nw - 1);
            end
            check("rand_idle_busy", busy, 0);
            tick(int'($urandom_range(0, 2)));
        end

        tick(2);
        check("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_keystream_ctrl.md
Name: lfsr_keystream_ctrl

Overview:
- Sequencer that configures and drives an internal Fibonacci-style LFSR datapath.
- Loads a seed and tap polynomial, runs a programmable warm-up (discarded bits), then packs successive feedback bits into OUT_WIDTH-bit words.
- Delivers words on a valid/ready stream.
- Sits between the config/control registers and any consumer of pseudo-random keystream, e.g. scramblers or test-pattern sources.

Parameters:
- LFSR_WIDTH, 6: LFSR state width W (≥2).
- OUT_WIDTH, 8: bits packed per output word (≥1).
- CNT_WIDTH, 8: width of the warm-up count.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a session; sampled in IDLE only
- stop  in  1  end the session; sampled outside IDLE only
- seed  in  LFSR_WIDTH  initial LFSR state, latched on accepted start
- coeff  in  LFSR_WIDTH+1  tap vector; coeff[W:1] used, coeff[0] ignored; latched on start
- warmup_cycles  in  CNT_WIDTH  number of discarded shifts after load
- out_word  out  OUT_WIDTH  packed keystream word
- out_valid  out  1  out_word valid
- out_ready  in  1  consumer accepts word
- busy  out  1  high in any state except IDLE
- seed_err  out  1  one-cycle pulse: start rejected because seed == 0
- lfsr_state  out  LFSR_WIDTH  current LFSR state

Behaviour:
- Shift definition:
  - fb = XOR-reduce(state & coeff_q[W:1]).
  - Shift updates state <= {state[W-2:0], fb}.
  - fb is the keystream bit produced by that shift.
- Reset: all outputs, the state register, the counters, the latched coeff and the stop_pending flag go to 0; FSM goes to IDLE. Reset mid-session aborts immediately; any pending word is lost.
- IDLE:
  - start=1 and seed≠0 → state<=seed, latch coeff and warmup_cycles. Next state is WARMUP if warmup_cycles≠0, else FILL.
  - start=1 and seed==0 → remain IDLE; seed_err=1 for exactly one cycle.
  - stop is ignored in IDLE.
- WARMUP:
  - One shift per cycle; bits discarded; counter counts the shifts.
  - After exactly warmup_cycles shifts → FILL.
- FILL:
  - One shift per cycle; shreg <= {shreg[OUT_WIDTH-2:0], fb}. The first bit ends at the MSB.
  - After OUT_WIDTH shifts, the final edge loads out_word and sets out_valid=1 → HOLD.
- HOLD:
  - No shifting; out_word and out_valid stay stable until out_valid & out_ready.
  - On handshake: out_valid<=0. Then → IDLE if stop_pending, else → FILL; the next word starts shifting in the following cycle.
  - Sustained throughput: one word per OUT_WIDTH+1 cycles.
- Latency: start accepted at edge k → out_valid first high after edge k+N+OUT_WIDTH, with N = warmup_cycles.
- stop:
  - stop=1 in WARMUP or FILL → IDLE at the next edge; the partial word is discarded and out_valid never rises.
  - stop=1 in HOLD → set stop_pending; valid stays up until the handshake, then → IDLE. stop and out_ready in the same HOLD cycle → IDLE after that edge.
  - stop_pending clears on entering IDLE.
- start while busy: ignored; no re-seed.
- lfsr_state: always equals the state register. It keeps its value in IDLE after a session ends.
- A zero state reached through taps (degenerate polynomial) is not detected; zero words are produced.

Test Plan:
- Base config for all scenarios: W=4, OUT_WIDTH=8, coeff=5'b10010, seed=4'b0001.
- warmup=0, out_ready=1 → out_valid 8 cycles after start; out_word=0xEB; lfsr_state=4'b1011; busy=1.
- warmup=4 → first out_word=0xB2; lfsr_state=4'b0010; out_valid 12 cycles after start.
- out_ready held 0 for 5 cycles in HOLD → out_word and out_valid stable, lfsr_state frozen. Ready then rises → one handshake; next word follows after 8 more shift cycles.
- seed=0 with start → seed_err high exactly 1 cycle; busy stays 0; lfsr_state unchanged.
- stop pulse during FILL bit 3 → IDLE the next cycle, no out_valid. stop during HOLD → word still delivered, then busy=0.
- rst asserted in WARMUP, and again in HOLD with out_valid=1 → next cycle all outputs 0, FSM in IDLE. A new start then works normally.
